// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer. Issues one request per PC to instruction
// memory and then presents {pc, instr} to decode until decode accepts the next PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        if_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pca4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fault
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic        npc_legal;
  logic        accept;

  assign npc_legal = (npc_in[1:0] == 2'b00) && (npc_in >= PC_LO) && (npc_in <= PC_HI);
  assign accept    = (state_q == S_HOLD) && if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // The offending address is still loaded into pc so it can be inspected after a fault.
        if (accept) begin
          pc_d = npc_in;
          if (npc_legal) begin
            state_d = S_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pca4        = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign fault       = fault_q;

endmodule
